// File: rtl/paced_dual_op_adder.sv
// rtl/paced_dual_op_adder.sv - paced two-operand add/sub/accumulate unit with tick-enable sampling
module paced_dual_op_adder #(
  parameter int WIDTH = 7,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       mode,
  input  logic             clr_acc,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  output logic             ovf
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic [WIDTH+1:0] acc_sum;

  assign tick = en & (cnt == CNT_LAST);

  // The extra bit of acc_sum is the carry out of bit WIDTH; it only feeds ovf.
  always_comb begin
    add_res = {1'b0, a_in} + {1'b0, b_in};
    sub_res = {1'b0, a_in} - {1'b0, b_in};
    acc_sum = {1'b0, result} + {2'b00, a_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (en) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end

      out_valid <= 1'b0;
      if (clr_acc) begin
        result <= '0;
        ovf    <= 1'b0;
      end else if (tick) begin
        case (mode)
          MODE_ADD: begin
            result    <= add_res;
            out_valid <= 1'b1;
          end
          MODE_SUB: begin
            result    <= sub_res;
            out_valid <= 1'b1;
          end
          MODE_ACC: begin
            result    <= acc_sum[WIDTH:0];
            out_valid <= 1'b1;
            if (acc_sum[WIDTH+1]) begin
              ovf <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_paced_dual_op_adder.sv
// tb/tb_paced_dual_op_adder.sv - randomized and directed check of paced_dual_op_adder against a behavioural model
module tb_paced_dual_op_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       clr_acc;
  logic [6:0] a0, b0;
  logic [3:0] a1, b1;
  logic [7:0] r0;
  logic [4:0] r1;
  logic       v0, v1, o0, o1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  int m_phase[2];
  int m_res[2];
  int m_val[2];
  int m_ovf[2];

  always #5 clk = ~clk;

  paced_dual_op_adder #(.WIDTH(7), .DIV(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .a_in(a0), .b_in(b0), .mode(mode),
    .clr_acc(clr_acc), .result(r0), .out_valid(v0), .ovf(o0)
  );

  paced_dual_op_adder #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .a_in(a1), .b_in(b1), .mode(mode),
    .clr_acc(clr_acc), .result(r1), .out_valid(v1), .ovf(o1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a tick falls on every DIV-th enabled cycle since reset; arithmetic is mod 2^(w+1).
  task automatic model_step(input int k, input int w, input int d, input int a, input int b);
    int m;
    int s;
    bit tk;
    m = 1 << (w + 1);
    if (rst) begin
      m_phase[k] = 0; m_res[k] = 0; m_val[k] = 0; m_ovf[k] = 0;
    end else begin
      tk = en && (m_phase[k] == d - 1);
      if (en) m_phase[k] = (m_phase[k] + 1) % d;
      m_val[k] = 0;
      if (clr_acc) begin
        m_res[k] = 0;
        m_ovf[k] = 0;
      end else if (tk) begin
        case (mode)
          2'd0: begin m_res[k] = (a + b) % m; m_val[k] = 1; end
          2'd1: begin m_res[k] = (a - b + m) % m; m_val[k] = 1; end
          2'd2: begin
            s = m_res[k] + a;
            if (s >= m) m_ovf[k] = 1;
            m_res[k] = s % m;
            m_val[k] = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 7, 2, int'(a0), int'(b0));
    model_step(1, 4, 1, int'(a1), int'(b1));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("res0", int'(r0), m_res[0]);
      chk("val0", int'(v0), m_val[0]);
      chk("ovf0", int'(o0), m_ovf[0]);
      chk("res1", int'(r1), m_res[1]);
      chk("val1", int'(v1), m_val[1]);
      chk("ovf1", int'(o1), m_ovf[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (v0) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  int n;

  initial begin
    rst = 1; en = 1; mode = 2'd0; clr_acc = 0;
    a0 = 7'd100; b0 = 7'd27; a1 = 4'd0; b1 = 4'd0;
    step(); step();
    chk_en = 1;
    chk("rst_res", int'(r0), 0);
    chk("rst_val", int'(v0), 0);
    rst = 0;

    wait_valid("add1", n);
    chk("first_lat", n, 2);
    chk("add_127", int'(r0), 127);
    chk("add_ovf", int'(o0), 0);
    step();
    chk("alt_low", int'(v0), 0);

    a0 = 7'd100; b0 = 7'd100;
    wait_valid("add2", n);
    chk("add_200", int'(r0), 200);
    mode = 2'd1; a0 = 7'd5; b0 = 7'd9;
    wait_valid("sub", n);
    chk("sub_252", int'(r0), 252);
    chk("sub_ovf", int'(o0), 0);

    clr_acc = 1; step(); clr_acc = 0;
    chk("clr_res", int'(r0), 0);
    mode = 2'd2; a0 = 7'd100;
    wait_valid("acc1", n); chk("acc_100", int'(r0), 100);
    wait_valid("acc2", n); chk("acc_200", int'(r0), 200);
    chk("acc_ovf0", int'(o0), 0);
    wait_valid("acc3", n); chk("acc_44", int'(r0), 44);
    chk("acc_ovf1", int'(o0), 1);
    mode = 2'd0; a0 = 7'd1; b0 = 7'd1;
    wait_valid("add3", n);
    chk("add_2", int'(r0), 2);
    chk("ovf_sticky", int'(o0), 1);
    step();
    clr_acc = 1; step(); clr_acc = 0;
    chk("clrtick_res", int'(r0), 0);
    chk("clrtick_ovf", int'(o0), 0);
    chk("clrtick_val", int'(v0), 0);

    a0 = 7'd3; b0 = 7'd4;
    wait_valid("pre_en", n);
    step();
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en0_val", int'(v0), 0);
    end
    en = 1;
    step();
    chk("en_resume_val", int'(v0), 1);
    chk("en_resume_res", int'(r0), 7);

    mode = 2'd2; a0 = 7'd10;
    wait_valid("acc_pre_rst", n);
    step();
    rst = 1; step(); rst = 0;
    chk("midrst_res", int'(r0), 0);
    chk("midrst_ovf", int'(o0), 0);
    wait_valid("post_rst", n);
    chk("post_rst_lat", n, 2);
    chk("post_rst_res", int'(r0), 10);

    mode = 2'd0; a1 = 4'd15; b1 = 4'd15;
    step();
    chk("d1_val_a", int'(v1), 1);
    chk("d1_res_a", int'(r1), 30);
    step();
    chk("d1_val_b", int'(v1), 1);
    mode = 2'd3;
    step();
    chk("d1_hold_val", int'(v1), 0);
    chk("d1_hold_res", int'(r1), 30);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) < 2);
      en      = ($urandom_range(0, 99) < 80);
      clr_acc = ($urandom_range(0, 99) < 4);
      mode    = 2'($urandom_range(0, 3));
      a0      = 7'($urandom);
      b0      = 7'($urandom);
      a1      = 4'($urandom);
      b1      = 4'($urandom);
      step();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
